// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants, pair type and channel-status helper.
// Used by spdif_transmit and spdif_bmc_encoder; no ports.
package spdif_pkg;

  localparam int HALFCELLS_PER_FRAME = 128;
  localparam int FRAMES_PER_BLOCK    = 192;

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  localparam int SLOT_AUDIO_LO = 4;
  localparam int SLOT_AUDIO_HI = 27;
  localparam int SLOT_V        = 28;
  localparam int SLOT_U        = 29;
  localparam int SLOT_C        = 30;
  localparam int SLOT_P        = 31;

  localparam int CS_COPY_BIT = 2;
  localparam int CS_FS_LO    = 24;
  localparam int CS_FS_HI    = 27;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } pair_t;

  // Consumer-format channel-status bit for a frame index.
  function automatic logic cs_bit(
    input logic [7:0] frame,
    input logic [3:0] fs
  );
    logic b;
    b = 1'b0;
    if (frame == 8'(CS_COPY_BIT))
      b = 1'b1;
    else if (frame >= 8'(CS_FS_LO) &&
             frame <= 8'(CS_FS_HI))
      b = fs[frame[1:0]];
    return b;
  endfunction

endpackage

// File: rtl/spdif_transmit_if.sv
// spdif_transmit_if: sample input bus and S/PDIF line/status outputs.
// master = sample source, slave = transmitter.
interface spdif_transmit_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] data_left;
  logic [WORD_SIZE-1:0] data_right;
  logic                 sample_valid;
  logic                 spdif_out;
  logic                 frame_start;
  logic                 block_start;
  logic                 underrun;
  logic                 overrun;

  modport master (
    output data_left, data_right, sample_valid,
    input  spdif_out, frame_start, block_start,
    input  underrun, overrun
  );

  modport slave (
    input  data_left, data_right, sample_valid,
    output spdif_out, frame_start, block_start,
    output underrun, overrun
  );
endinterface

// File: rtl/spdif_bmc_encoder.sv
// spdif_bmc_encoder: biphase-mark line register with preamble insertion.
// In: sck, rst, i_bit, i_pre_act, i_pre_pat, i_hc[2:0]. Out: o_line.
module spdif_bmc_encoder (
  input  logic       sck,
  input  logic       rst,
  input  logic       i_bit,
  input  logic       i_pre_act,
  input  logic [7:0] i_pre_pat,
  input  logic [2:0] i_hc,
  output logic       o_line
);

  logic       r_level;
  logic       r_pol;
  logic       w_next;
  logic       w_pol_next;
  logic [2:0] w_pidx;

  assign w_pidx = 3'd7 - i_hc;
  assign o_line = r_level;

  // Preamble polarity is latched from the level preceding it.
  always_comb begin
    w_next     = r_level;
    w_pol_next = r_pol;
    unique case (1'b1)
      (i_pre_act && i_hc == 3'd0): begin
        w_next     = i_pre_pat[7] ^ r_level;
        w_pol_next = r_level;
      end
      (i_pre_act && i_hc != 3'd0):
        w_next = i_pre_pat[w_pidx] ^ r_pol;
      (!i_pre_act && !i_hc[0]):
        w_next = ~r_level;
      (!i_pre_act && i_hc[0]):
        w_next = r_level ^ i_bit;
      default:
        w_next = r_level;
    endcase
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_pol   <= 1'b0;
    end else begin
      r_level <= w_next;
      r_pol   <= w_pol_next;
    end
  end

endmodule

// File: rtl/spdif_transmit.sv
// spdif_transmit: IEC 60958 transmitter, 24-bit audio, 192-frame blocks.
// Ports: sck (128 fs), rst (async low), bus (slave). Option: SPDIF_CHANNEL_STATUS_EN.
module spdif_transmit
  import spdif_pkg::*;
#(
  parameter int         WORD_SIZE = 32,
  parameter logic [3:0] CS_FS     = 4'b0000
) (
  input logic             sck,
  input logic             rst,
  spdif_transmit_if.slave bus
);

  logic [6:0] r_hc;
  logic [7:0] r_frame;
  pair_t      r_hold;
  pair_t      r_tx;
  logic       r_pending;
  logic       r_vflag;
  logic       r_ever;
  logic       r_fs;
  logic       r_bs;
  logic       r_under;
  logic       r_over;

  logic        w_load;
  logic        w_sub;
  logic [4:0]  w_slot;
  logic [4:0]  w_idx;
  logic [23:0] w_aud;
  logic        w_pre;
  logic        w_is_aud;
  logic        w_c;
  logic        w_par;
  logic        w_bit;
  logic [7:0]  w_pat;
  logic        w_line;

  // r_hc is the half-cell emitted at the next edge.
  assign w_load   = (r_hc == 7'd0);
  assign w_sub    = r_hc[6];
  assign w_slot   = r_hc[5:1];
  assign w_idx    = w_slot - 5'(SLOT_AUDIO_LO);
  assign w_aud    = w_sub ? r_tx.right : r_tx.left;
  assign w_pre    = (w_slot < 5'(SLOT_AUDIO_LO));
  assign w_is_aud = !w_pre &&
                    (w_slot <= 5'(SLOT_AUDIO_HI));

`ifdef SPDIF_CHANNEL_STATUS_EN
  assign w_c = cs_bit(r_frame, CS_FS);
`else
  logic [3:0] w_unused_fs;
  assign w_unused_fs = CS_FS;
  assign w_c = 1'b0;
`endif

  // U is always 0, so it drops out of the parity.
  assign w_par = ^w_aud ^ r_vflag ^ w_c;

  generate
    if (WORD_SIZE > 24) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb =
        ^{bus.data_left[WORD_SIZE-25:0],
          bus.data_right[WORD_SIZE-25:0]};
    end
  endgenerate

  always_comb begin
    w_bit = 1'b0;
    unique case (1'b1)
      w_pre:                   w_bit = 1'b0;
      w_is_aud:                w_bit = w_aud[w_idx];
      (w_slot == 5'(SLOT_V)):  w_bit = r_vflag;
      (w_slot == 5'(SLOT_U)):  w_bit = 1'b0;
      (w_slot == 5'(SLOT_C)):  w_bit = w_c;
      (w_slot == 5'(SLOT_P)):  w_bit = w_par;
      default:                 w_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_pat = PRE_M;
    unique case (1'b1)
      w_sub:                      w_pat = PRE_W;
      (!w_sub && r_frame == '0):  w_pat = PRE_B;
      (!w_sub && r_frame != '0):  w_pat = PRE_M;
      default:                    w_pat = PRE_M;
    endcase
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      r_hc      <= '0;
      r_frame   <= '0;
      r_hold    <= '0;
      r_tx      <= '0;
      r_pending <= 1'b0;
      r_vflag   <= 1'b0;
      r_ever    <= 1'b0;
      r_fs      <= 1'b0;
      r_bs      <= 1'b0;
      r_under   <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_hc <= (r_hc == 7'(HALFCELLS_PER_FRAME-1))
            ? '0 : r_hc + 7'd1;
      if (r_hc == 7'(HALFCELLS_PER_FRAME-1))
        r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK-1))
                 ? '0 : r_frame + 8'd1;
      r_fs    <= w_load;
      r_bs    <= w_load && (r_frame == '0);
      r_under <= w_load && !r_pending && r_ever;
      // A pending pair consumed on this edge is not overwritten.
      r_over  <= bus.sample_valid && r_pending && !w_load;
      if (w_load) begin
        r_vflag <= !r_pending;
        if (r_pending) begin
          r_tx   <= r_hold;
          r_ever <= 1'b1;
        end
      end
      if (bus.sample_valid)
        r_hold <= {bus.data_left[WORD_SIZE-1 -: 24],
                   bus.data_right[WORD_SIZE-1 -: 24]};
      r_pending <= bus.sample_valid ||
                   (r_pending && !w_load);
    end
  end

  spdif_bmc_encoder u_bmc (
    .sck       (sck),
    .rst       (rst),
    .i_bit     (w_bit),
    .i_pre_act (w_pre),
    .i_pre_pat (w_pat),
    .i_hc      (r_hc[2:0]),
    .o_line    (w_line)
  );

  assign bus.spdif_out   = w_line;
  assign bus.frame_start = r_fs;
  assign bus.block_start = r_bs;
  assign bus.underrun    = r_under;
  assign bus.overrun     = r_over;

endmodule

// File: tb/tb_spdif_transmit.sv
// tb_spdif_transmit: decodes the S/PDIF line and scores frames
// against expectations queued as stimulus is driven.
module tb_spdif_transmit;

  localparam logic [7:0] PB = 8'b11101000;
  localparam logic [7:0] PM = 8'b11100010;
  localparam logic [7:0] PW = 8'b11100100;

  typedef struct {
    int          frame;
    logic [23:0] l;
    logic [23:0] r;
    logic        v;
    logic        und;
  } exp_t;

  logic sck = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   edge_cnt = -1;
  logic hbuf [128];
  logic prev_last = 1'b0;
  logic und_seen = 1'b0;
  int   ovr_cnt = 0;
  int   und_cnt = 0;
  int   bs_cnt = 0;
  int   c_ones = 0;
  exp_t sb [$];

  spdif_transmit_if #(.WORD_SIZE(32)) bus ();

  spdif_transmit #(
    .WORD_SIZE (32),
    .CS_FS     (4'b0010)
  ) dut (
    .sck (sck),
    .rst (rst),
    .bus (bus)
  );

  always #5 sck = ~sck;

  // Index of the half-cell emitted by the latest edge.
  always @(posedge sck)
    edge_cnt <= rst ? edge_cnt + 1 : -1;

  function automatic logic exp_c(input int n);
`ifdef SPDIF_CHANNEL_STATUS_EN
    return (n == 2) || (n == 25);
`else
    return (n < 0);
`endif
  endfunction

  function automatic void push(
    input int f, input logic [23:0] l,
    input logic [23:0] r, input logic v,
    input logic u
  );
    exp_t e;
    e.frame = f; e.l = l; e.r = r;
    e.v = v; e.und = u;
    sb.push_back(e);
  endfunction

  task automatic decode_frame(input int frm);
    logic [7:0]  pre;
    logic [7:0]  want;
    logic        prev;
    logic        ok;
    logic [31:0] bits;
    logic [23:0] aud [2];
    logic        v [2];
    int          b;
    exp_t        e;
    for (int s = 0; s < 2; s++) begin
      b = 64 * s;
      prev = (s == 0) ? prev_last : hbuf[63];
      for (int i = 0; i < 8; i++)
        pre[7-i] = hbuf[b+i] ^ prev;
      want = (s == 1) ? PW :
             ((frm % 192 == 0) ? PB : PM);
      n_tests++;
      if (pre !== want) begin
        n_fail++;
        $display("FAIL preamble f%0d s%0d: got %b want %b",
                 frm, s, pre, want);
      end
      ok = 1'b1;
      bits = '0;
      for (int k = 4; k < 32; k++) begin
        if (hbuf[b+2*k] === hbuf[b+2*k-1]) ok = 1'b0;
        bits[k] = hbuf[b+2*k] ^ hbuf[b+2*k+1];
      end
      n_tests++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL bmc f%0d s%0d: slot start without toggle",
                 frm, s);
      end
      n_tests++;
      if ((^bits) !== 1'b0) begin
        n_fail++;
        $display("FAIL parity f%0d s%0d: got odd want even",
                 frm, s);
      end
      n_tests++;
      if (bits[29] !== 1'b0) begin
        n_fail++;
        $display("FAIL ubit f%0d s%0d: got %b want 0",
                 frm, s, bits[29]);
      end
      n_tests++;
      if (bits[30] !== exp_c(frm % 192)) begin
        n_fail++;
        $display("FAIL cbit f%0d s%0d: got %b want %b",
                 frm, s, bits[30], exp_c(frm % 192));
      end
      if (s == 0 && frm < 192 && bits[30] === 1'b1)
        c_ones++;
      aud[s] = bits[27:4];
      v[s] = bits[28];
    end
    if (sb.size() > 0 && sb[0].frame == frm) begin
      e = sb.pop_front();
      n_tests++;
      if (aud[0] !== e.l) begin
        n_fail++;
        $display("FAIL audio_l f%0d: got %h want %h",
                 frm, aud[0], e.l);
      end
      n_tests++;
      if (aud[1] !== e.r) begin
        n_fail++;
        $display("FAIL audio_r f%0d: got %h want %h",
                 frm, aud[1], e.r);
      end
      n_tests++;
      if (v[0] !== e.v || v[1] !== e.v) begin
        n_fail++;
        $display("FAIL vbit f%0d: got %b/%b want %b",
                 frm, v[0], v[1], e.v);
      end
      n_tests++;
      if (und_seen !== e.und) begin
        n_fail++;
        $display("FAIL underrun f%0d: got %b want %b",
                 frm, und_seen, e.und);
      end
    end
  endtask

  always @(negedge sck) begin : mon
    int pos;
    int frm;
    if (!rst) begin
      prev_last = 1'b0;
      und_seen = 1'b0;
    end else if (edge_cnt >= 0) begin
      pos = edge_cnt % 128;
      frm = edge_cnt / 128;
      n_tests++;
      if (bus.frame_start !== (pos == 0)) begin
        n_fail++;
        $display("FAIL frame_start e%0d: got %b want %b",
                 edge_cnt, bus.frame_start, pos == 0);
      end
      n_tests++;
      if (bus.block_start !==
          (pos == 0 && frm % 192 == 0)) begin
        n_fail++;
        $display("FAIL block_start e%0d: got %b want %b",
                 edge_cnt, bus.block_start,
                 pos == 0 && frm % 192 == 0);
      end
      if (bus.underrun === 1'b1) begin
        und_seen = 1'b1;
        und_cnt++;
      end
      if (bus.overrun === 1'b1) ovr_cnt++;
      if (bus.block_start === 1'b1) bs_cnt++;
      hbuf[pos] = bus.spdif_out;
      if (pos == 127) begin
        decode_frame(frm);
        prev_last = bus.spdif_out;
        und_seen = 1'b0;
      end
    end
  end

  task automatic goto(input int e);
    int n = 0;
    while (edge_cnt < e && n < 60000) begin
      @(posedge sck); #1;
      n++;
    end
    n_tests++;
    if (edge_cnt != e) begin
      n_fail++;
      $display("FAIL goto: got edge %0d want %0d",
               edge_cnt, e);
    end
  endtask

  // Pair is captured at edge e, i.e. during frame e/128.
  task automatic strobe(
    input int e, input logic [31:0] l,
    input logic [31:0] r
  );
    goto(e - 1);
    bus.data_left = l;
    bus.data_right = r;
    bus.sample_valid = 1'b1;
    @(posedge sck); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge sck);
      n_tests++;
      if ({bus.spdif_out, bus.frame_start, bus.block_start,
           bus.underrun, bus.overrun} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outs: got %b%b%b%b%b want 00000",
                 bus.spdif_out, bus.frame_start,
                 bus.block_start, bus.underrun, bus.overrun);
      end
    end
    @(posedge sck); #2;
    rst = 1'b1;
    push(0, 24'h0, 24'h0, 1'b1, 1'b0);
    push(1, 24'h0, 24'h0, 1'b1, 1'b0);
    push(2, 24'h0, 24'h0, 1'b1, 1'b0);
  endtask

  task automatic test_audio();
    strobe(2*128 + 10, 32'h12345600, 32'hABCDEF00);
    push(3, 24'h123456, 24'hABCDEF, 1'b0, 1'b0);
  endtask

  task automatic test_underrun();
    int u0;
    push(4, 24'h123456, 24'hABCDEF, 1'b1, 1'b1);
    push(5, 24'h123456, 24'hABCDEF, 1'b1, 1'b1);
    goto(4*128 - 1);
    u0 = und_cnt;
    goto(5*128);
    n_tests++;
    if (und_cnt - u0 != 1) begin
      n_fail++;
      $display("FAIL underrun_pulses: got %0d want 1",
               und_cnt - u0);
    end
  endtask

  task automatic test_overrun();
    int o0;
    push(6, 24'h123456, 24'hABCDEF, 1'b1, 1'b1);
    o0 = ovr_cnt;
    strobe(6*128 + 20, 32'h11111100, 32'h11111100);
    strobe(6*128 + 40, 32'h22222200, 32'h22222200);
    push(7, 24'h222222, 24'h222222, 1'b0, 1'b0);
    goto(7*128 + 64);
    n_tests++;
    if (ovr_cnt - o0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulses: got %0d want 1",
               ovr_cnt - o0);
    end
  endtask

  task automatic test_load_edge();
    push(8, 24'h222222, 24'h222222, 1'b1, 1'b1);
    push(9, 24'h222222, 24'h222222, 1'b1, 1'b1);
    strobe(9*128, 32'h89ABCDEF, 32'h5A5A5AFF);
    push(10, 24'h89ABCD, 24'h5A5A5A, 1'b0, 1'b0);
    goto(11*128 + 2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL load_edge_queue: got %0d left want 0",
               sb.size());
    end
  endtask

  task automatic test_block();
    goto(193*128 + 2);
    n_tests++;
    if (bs_cnt != 2) begin
      n_fail++;
      $display("FAIL block_count: got %0d want 2", bs_cnt);
    end
    n_tests++;
`ifdef SPDIF_CHANNEL_STATUS_EN
    if (c_ones != 2) begin
      n_fail++;
      $display("FAIL cs_ones: got %0d want 2", c_ones);
    end
`else
    if (c_ones != 0) begin
      n_fail++;
      $display("FAIL cs_ones: got %0d want 0", c_ones);
    end
`endif
  endtask

  task automatic test_midreset();
    goto(193*128 + 70);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.spdif_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_line: got %b want 0",
               bus.spdif_out);
    end
    n_tests++;
    if ({bus.frame_start, bus.block_start,
         bus.underrun, bus.overrun} !== 4'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b%b%b%b want 0000",
               bus.frame_start, bus.block_start,
               bus.underrun, bus.overrun);
    end
    repeat (3) @(posedge sck);
    #2;
    rst = 1'b1;
    push(0, 24'h0, 24'h0, 1'b1, 1'b0);
    push(1, 24'h0, 24'h0, 1'b1, 1'b0);
    goto(2*128 + 2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_queue: got %0d left want 0",
               sb.size());
    end
  endtask

  initial begin
    bus.data_left = '0;
    bus.data_right = '0;
    bus.sample_valid = 1'b0;
    #1 rst = 1'b0;
    test_reset();
    test_audio();
    test_underrun();
    test_overrun();
    test_load_edge();
    test_block();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
